fft_twiddle_sequencer: RTL

- Reader/consumer side of the twiddle-factor ROM bus.
- Takes the flat 16-entry real/imag twiddle buses and walks a full radix-2 DIT schedule for a 32-point FFT: 5 stages × 16 butterflies.
- For each butterfly it presents the butterfly datapath with:
  - the selected twiddle (optionally conjugated for IFFT);
  - the top/bottom data addresses;
  - a valid/ready handshake.

---
 rtl/fft_twiddle_sequencer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/fft_twiddle_sequencer.sv
// fft_twiddle_sequencer: walks a radix-2 DIT schedule (LOG2N stages x N/2 butterflies) and presents
// per-butterfly twiddle, data addresses and a valid/ready beat to the butterfly datapath.
`default_nettype none

module fft_twiddle_sequencer #(
    parameter int N     = 32,
    parameter int WIDTH = 16,
    parameter int LOG2N = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      inverse,
    input  logic [(N/2)*WIDTH-1:0]    tw_real_bus,
    input  logic [(N/2)*WIDTH-1:0]    tw_img_bus,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          tw_real,
    output logic [WIDTH-1:0]          tw_img,
    output logic [LOG2N-2:0]          tw_index,
    output logic [LOG2N-1:0]          addr_top,
    output logic [LOG2N-1:0]          addr_bot,
    output logic [2:0]                stage,
    output logic                      last,
    output logic                      busy,
    output logic                      done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};

    state_t           state, state_n;
    logic [2:0]       s_q, s_n;
    logic [LOG2N-2:0] b_q, b_n;
    logic             inv_q, inv_n;
    logic             load, finish;

    logic [LOG2N-1:0] mask, b_ext, low, k_full, top_n, bot_n;
    logic [LOG2N-2:0] k_n;
    logic [WIDTH-1:0] re_sel, im_sel, im_neg, im_n;
    logic             last_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        finish  = 1'b0;
        s_n     = s_q;
        b_n     = b_q;
        inv_n   = inv_q;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n = ST_RUN;
                    load    = 1'b1;
                    s_n     = 3'd0;
                    b_n     = '0;
                    inv_n   = inverse;
                end
            end
            ST_RUN: begin
                if (out_valid && out_ready) begin
                    if (last) begin
                        state_n = ST_DONE;
                        finish  = 1'b1;
                    end else begin
                        load = 1'b1;
                        if (b_q == '1) begin
                            b_n = '0;
                            s_n = s_q + 3'd1;
                        end else begin
                            b_n = b_q + 1'b1;
                        end
                    end
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Index/address generation for the beat about to be loaded (half = 2^s).
    always_comb begin
        mask   = (LOG2N'(1) << s_n) - LOG2N'(1);
        b_ext  = {1'b0, b_n};
        low    = b_ext & mask;
        top_n  = ((b_ext >> s_n) << (s_n + 3'd1)) | low;
        bot_n  = top_n + (LOG2N'(1) << s_n);
        k_full = low << (3'(LOG2N - 1) - s_n);
        k_n    = k_full[LOG2N-2:0];
        last_n = (s_n == 3'(LOG2N - 1)) && (b_n == '1);
    end

    // Entry k sits at slice N/2-1-k, i.e. ~k, so k=0 lands in the MSBs.
    always_comb begin
        re_sel = tw_real_bus[int'(~k_n)*WIDTH +: WIDTH];
        im_sel = tw_img_bus[int'(~k_n)*WIDTH +: WIDTH];
        im_neg = (im_sel == MOST_NEG) ? MOST_POS : (~im_sel + 1'b1);
        im_n   = inv_n ? im_neg : im_sel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q       <= '0;
            b_q       <= '0;
            inv_q     <= 1'b0;
            out_valid <= 1'b0;
            tw_real   <= '0;
            tw_img    <= '0;
            tw_index  <= '0;
            addr_top  <= '0;
            addr_bot  <= '0;
            last      <= 1'b0;
        end else if (load) begin
            s_q       <= s_n;
            b_q       <= b_n;
            inv_q     <= inv_n;
            out_valid <= 1'b1;
            tw_real   <= re_sel;
            tw_img    <= im_n;
            tw_index  <= k_n;
            addr_top  <= top_n;
            addr_bot  <= bot_n;
            last      <= last_n;
        end else if (finish) begin
            out_valid <= 1'b0;
            last      <= 1'b0;
        end
    end

    assign stage = s_q;
    assign busy  = (state != ST_IDLE);
    assign done  = (state == ST_DONE);

endmodule

`default_nettype wire
